// File: rtl/vend_fsm_param.sv
// vend_fsm_param: parametrised vending controller.
// Takes 50c (1 unit) and $1 (2 unit) coins, vends at PRICE_UNITS, returns change
// as a unit count, refunds on cancel and flags coins that arrive while busy.
// Optional macro VEND_TIMEOUT_EN: refund COLLECT credit after TIMEOUT_CYCLES idle cycles.
module vend_fsm_param #(
  parameter int PRICE_UNITS    = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW            = $clog2(PRICE_UNITS + 3)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifty,
  input  logic          dollar,
  input  logic          cancel,
  output logic          dispense,
  output logic          money_return,
  output logic [CW-1:0] change_units,
  output logic [CW-1:0] credit,
  output logic          insert_coin,
  output logic          coin_reject,
  output logic [1:0]    sst
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam logic [CW-1:0] PRICE = CW'(PRICE_UNITS);

  // Reject nonsensical configurations at elaboration.
  if (PRICE_UNITS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("vend_fsm_param: PRICE_UNITS must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  state_t        state;
  logic [CW-1:0] credit_q;
  logic [CW-1:0] change_q;
  logic          reject_q;
  logic [CW-1:0] add;
  logic [CW-1:0] nc;

  // Coin value this cycle and the credit it would produce.
  always_comb begin
    add = CW'(fifty) + (dollar ? CW'(2) : '0);
    nc  = credit_q + add;
  end

`ifdef VEND_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;
  logic          expired;

  assign expired = (state == COLLECT) && (idle_cnt == TMAX);

  // Idle counter: counts quiet COLLECT cycles; any coin, cancel, expiry or other state clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (state == COLLECT && add == '0 && !cancel && !expired)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end
`endif

  // Main FSM: state, credit, change and the late coin-reject pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (cancel && nc != '0) begin
            // Cancel beats vend; a same-cycle coin is refunded too.
            state    <= REFUND;
            change_q <= nc;
            credit_q <= '0;
          end else if (nc >= PRICE) begin
            state    <= VEND;
            change_q <= nc - PRICE;
            credit_q <= '0;
          end else if (add != '0) begin
            state    <= COLLECT;
            credit_q <= nc;
`ifdef VEND_TIMEOUT_EN
          end else if (expired) begin
            state    <= REFUND;
            change_q <= credit_q;
            credit_q <= '0;
`endif
          end
          // otherwise hold state and credit
        end
        default: begin
          // VEND / REFUND last one cycle; coins here are dropped and flagged.
          reject_q <= fifty | dollar;
          state    <= IDLE;
          change_q <= '0;
        end
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    dispense     = (state == VEND);
    money_return = (state == REFUND) || (state == VEND && change_q != '0);
    insert_coin  = (state == IDLE) || (state == COLLECT);
    change_units = change_q;
    credit       = credit_q;
    coin_reject  = reject_q;
    sst          = state;
  end

endmodule

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
- Parametrised vending-machine controller; next generation of the fixed two-coin, fixed-price vend FSM.
- Accepts 50-cent and 1-dollar coins, accumulates credit in 50-cent units up to a programmable price, and dispenses.
- Reports change as a unit count, refunds on cancel, and flags coins rejected while busy.
- Sits between the coin-acceptor/button front end and the dispenser/payout drivers.

Parameters:
- PRICE_UNITS, 3, item price in 50-cent units (must be >= 1); 3 = $1.50.
- TIMEOUT_CYCLES, 1024, inactivity limit in clk cycles; used only when VEND_TIMEOUT_EN is defined (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifty  input  1  50-cent coin strobe; one coin per cycle high.
- dollar  input  1  1-dollar coin strobe; one coin per cycle high.
- cancel  input  1  refund request.
- dispense  output  1  one-cycle dispense pulse.
- money_return  output  1  one-cycle payout pulse; valid with change_units.
- change_units  output  CW  payout amount in 50-cent units; CW = $clog2(PRICE_UNITS+3).
- credit  output  CW  current accumulated credit.
- insert_coin  output  1  high when coins are accepted.
- coin_reject  output  1  one-cycle pulse: a coin arrived while not accepting.
- sst  output  2  state code.

Behaviour:
- States and sst codes: IDLE=0, COLLECT=1, VEND=2, REFUND=3.
- Outputs are Moore, decoded from registered state/credit/change, except coin_reject, which is a registered pulse one cycle after the offending strobe.
- Async reset: state IDLE, credit 0, change_units 0, dispense 0, money_return 0, coin_reject 0, sst 0.
  - insert_coin is 1 during and after reset.
  - Reset mid-transaction discards credit with no payout pulse.
- Coin value per cycle: add = fifty*1 + dollar*2. fifty and dollar high together in one cycle add 3.
- IDLE and COLLECT:
  - insert_coin=1.
  - nc = credit + add.
  - If cancel=1 and nc>0: go REFUND, change_units<=nc. Cancel wins over vend; a coin in the same cycle is included in the refund.
  - Else if nc >= PRICE_UNITS: go VEND, change_units<=nc-PRICE_UNITS, credit<=0.
  - Else if nc>0: go COLLECT, credit<=nc.
  - Else: stay in the current state.
  - cancel with nc=0 in IDLE is ignored; no pulse.
- VEND, exactly 1 cycle:
  - dispense=1, insert_coin=0.
  - money_return=1 iff change_units>0.
  - Next state IDLE; change_units clears to 0 on exit.
- REFUND, exactly 1 cycle:
  - money_return=1, insert_coin=0, credit reads 0.
  - Next state IDLE; change_units clears on exit.
- Coin strobe while in VEND/REFUND: coin ignored, no credit; coin_reject=1 the next cycle. cancel in these states is ignored.
- Latency: strobe sampled at edge k gives the new credit/state visible after edge k; dispense/money_return are high for the cycle between edges k and k+1.
- Max credit: PRICE_UNITS+2, so CW never overflows. There is no wrap-around case.

Optional Feature:
- Macro VEND_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT. It resets to 0 on any accepted coin and on entry to COLLECT.
  - When the counter reaches TIMEOUT_CYCLES-1 with no coin and no cancel, the next state is REFUND with change_units=credit.
  - A coin arriving in the expiry cycle takes priority: it is accepted and the counter resets.
  - The counter is held at 0 in all other states and on reset.
- Not defined: no counter logic exists; COLLECT waits indefinitely.

Test Plan:
- PRICE_UNITS=3, fifty pulsed 3 times, one cycle apart: credit 1, 2, then VEND; dispense 1 cycle; money_return=0; change_units=0; back to IDLE with credit 0.
- dollar, dollar: credit 2, then VEND; dispense=1; money_return=1; change_units=1; sst 0→1→2→0.
- fifty, then cancel 2 cycles later: REFUND; money_return=1; change_units=1; dispense=0; then IDLE with credit 0. Also: cancel alone in IDLE gives no pulses.
- Credit 2, then fifty and dollar in the same cycle: VEND with change_units=2. Separately: credit 1, then cancel+dollar in the same cycle gives REFUND with change_units=3.
- fifty strobed during the VEND cycle: coin_reject pulses 1 cycle; credit stays 0; no later dispense. Separately: assert rst while in COLLECT with credit 2: all outputs go to reset values immediately, with no money_return.
- VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8: fifty then 8 quiet cycles gives REFUND with change_units=1. Same run with a fifty on quiet cycle 7: no refund, credit 2, timer restarts.
